// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage types: multiply/divide opcodes, FSM states and
// operand-signedness helpers used by muldiv_unit.
package riscv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  function automatic logic md_is_div(input md_op_t op);
    return (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU});
  endfunction

  function automatic logic md_is_rem(input md_op_t op);
    return (op inside {MD_REM, MD_REMU});
  endfunction

  // MUL is treated as unsigned: its low word does not depend on signedness.
  function automatic logic md_a_signed(input md_op_t op);
    return (op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
  endfunction

  function automatic logic md_b_signed(input md_op_t op);
    return (op inside {MD_MULH, MD_DIV, MD_REM});
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 iteration datapath: shift-add multiply or restoring divide on
// unsigned magnitudes, one step per cycle. {hi,lo} is the product, or rem/quot.
module muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;
  logic            r_is_div;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift_hi;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_nxt_hi;
  logic [XLEN-1:0] w_nxt_lo;

  // Trial subtraction borrow (bit XLEN) selects restore vs. keep.
  always_comb begin
    w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_shift_hi = {r_hi, r_lo[XLEN-1]};
    w_trial    = w_shift_hi - {1'b0, r_opnd};
    if (r_is_div) begin
      w_nxt_hi = w_trial[XLEN] ? w_shift_hi[XLEN-1:0] : w_trial[XLEN-1:0];
      w_nxt_lo = {r_lo[XLEN-2:0], ~w_trial[XLEN]};
    end else begin
      w_nxt_hi = w_sum[XLEN:1];
      w_nxt_lo = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_hi     <= '0;
      r_lo     <= i_is_div ? i_a : i_b;
      r_opnd   <= i_is_div ? i_b : i_a;
      r_is_div <= i_is_div;
    end else if (i_step) begin
      r_hi <= w_nxt_hi;
      r_lo <= w_nxt_lo;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, handshake, sign fix-up and the
// RISC-V divide-by-zero / signed-overflow fast paths around muldiv_datapath.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int              CNT_W    = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       r_state;
  md_state_t       w_state_nxt;
  md_op_t          r_op;
  logic            r_neg;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  logic            w_accept;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_fast;
  logic            w_neg_in;
  logic [XLEN-1:0] w_fast_res;
  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_fix_res;

  // Request decode: magnitudes, result sign and fast-path detection.
  always_comb begin
    w_accept   = in_valid && (r_state == MD_IDLE) && !kill;
    w_a_neg    = md_a_signed(op) && a[XLEN-1];
    w_b_neg    = md_b_signed(op) && b[XLEN-1];
    w_a_mag    = w_a_neg ? -a : a;
    w_b_mag    = w_b_neg ? -b : b;
    w_neg_in   = md_is_rem(op) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero = md_is_div(op) && (b == '0);
    w_ovf      = (op inside {MD_DIV, MD_REM}) && (a == SMIN) && (b == '1);
    w_fast     = w_div_zero || w_ovf;
    w_fast_res = '0;
    if (w_div_zero)
      w_fast_res = md_is_rem(op) ? a : '1;
    else if (w_ovf)
      w_fast_res = md_is_rem(op) ? '0 : a;
  end

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk      (clk),
    .i_load   (w_accept && !w_fast),
    .i_step   (r_state == MD_BUSY),
    .i_is_div (md_is_div(op)),
    .i_a      (w_a_mag),
    .i_b      (w_b_mag),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  always_comb begin
    w_prod = r_neg ? -{w_hi, w_lo} : {w_hi, w_lo};
    unique case (r_op)
      MD_MUL:                     w_fix_res = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:            w_fix_res = r_neg ? -w_lo : w_lo;
      default:                    w_fix_res = r_neg ? -w_hi : w_hi;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      MD_IDLE: if (w_accept) w_state_nxt = w_fast ? MD_DONE : MD_BUSY;
      MD_BUSY: if (r_cnt == CNT_LAST) w_state_nxt = MD_FIX;
      MD_FIX:  w_state_nxt = MD_DONE;
      MD_DONE: if (out_ready) w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
    if (kill) w_state_nxt = MD_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MD_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request latch, iteration counter and the registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= MD_MUL;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (w_accept) begin
      r_op  <= op;
      r_neg <= w_neg_in;
      r_cnt <= '0;
      if (w_fast) begin
        r_result <= w_fast_res;
        r_zero   <= (w_fast_res == '0);
      end
    end else if (r_state == MD_BUSY) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (r_state == MD_FIX && !kill) begin
      r_result <= w_fix_res;
      r_zero   <= (w_fix_res == '0);
    end
  end

  assign in_ready  = (r_state == MD_IDLE);
  assign out_valid = (r_state == MD_DONE);
  assign result    = r_result;
  assign zero      = r_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at XLEN=32 and XLEN=16: directed RV32M cases, random
// operations against a wide-arithmetic reference model, backpressure, kill and reset.
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        kill = 1'b0;
  logic        out_ready = 1'b0;
  logic        sel16 = 1'b0;
  md_op_t      op = MD_MUL;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        rdy32, vld32, z32, rdy16, vld16, z16;
  logic [31:0] res32;
  logic [15:0] res16;
  logic        cur_rdy, cur_vld, cur_zero;
  logic [31:0] cur_res;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel16), .in_ready(rdy32),
    .op(op), .a(a), .b(b), .kill(kill), .out_valid(vld32), .out_ready(out_ready),
    .result(res32), .zero(z32)
  );

  muldiv_unit #(.XLEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel16), .in_ready(rdy16),
    .op(op), .a(a[15:0]), .b(b[15:0]), .kill(kill), .out_valid(vld16), .out_ready(out_ready),
    .result(res16), .zero(z16)
  );

  assign cur_rdy  = sel16 ? rdy16 : rdy32;
  assign cur_vld  = sel16 ? vld16 : vld32;
  assign cur_zero = sel16 ? z16 : z32;
  assign cur_res  = sel16 ? {16'h0000, res16} : res32;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // Reference: exact 128-bit products and 64-bit C-style division.
  function automatic logic [31:0] ref_res(input int w, input md_op_t o,
                                          input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mask, smin, xm, ym;
    logic signed [127:0] ux, uy, sx, sy, p;
    longint lx, ly, q;
    mask = wmask(w);
    smin = mask ^ (mask >> 1);
    xm = x & mask;
    ym = y & mask;
    ux = {96'd0, xm};
    uy = {96'd0, ym};
    sx = ((xm & smin) != 0) ? ux - (128'sd1 <<< w) : ux;
    sy = ((ym & smin) != 0) ? uy - (128'sd1 <<< w) : uy;
    lx = sx[63:0];
    ly = sy[63:0];
    p  = '0;
    case (o)
      MD_MUL:    p = ux * uy;
      MD_MULH:   p = (sx * sy) >>> w;
      MD_MULHSU: p = (sx * uy) >>> w;
      MD_MULHU:  p = (ux * uy) >> w;
      MD_DIV: begin
        if (ym == 0) p = {96'd0, mask};
        else if (xm == smin && ym == mask) p = ux;
        else begin q = lx / ly; p = {64'd0, q}; end
      end
      MD_DIVU:   p = (ym == 0) ? {96'd0, mask} : ux / uy;
      MD_REM: begin
        if (ym == 0) p = ux;
        else if (xm == smin && ym == mask) p = '0;
        else begin q = lx % ly; p = {64'd0, q}; end
      end
      default:   p = (ym == 0) ? ux : ux % uy;
    endcase
    return p[31:0] & mask;
  endfunction

  function automatic int ref_lat(input int w, input md_op_t o,
                                 input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mask, smin;
    logic is_div, fast;
    mask   = wmask(w);
    smin   = mask ^ (mask >> 1);
    is_div = (o == MD_DIV) || (o == MD_DIVU) || (o == MD_REM) || (o == MD_REMU);
    fast   = (is_div && (y & mask) == 0) ||
             ((o == MD_DIV || o == MD_REM) && (x & mask) == smin && (y & mask) == mask);
    return fast ? 1 : w + 1;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask;
    mask = wmask(w);
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return mask;
      3:       return mask ^ (mask >> 1);
      default: return $urandom & mask;
    endcase
  endfunction

  task automatic issue(input md_op_t o, input logic [31:0] x, input logic [31:0] y);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cur_rdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", 32'(cur_rdy), 32'd1);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = md_op_t'($urandom_range(0, 7));
    a = $urandom;
    b = $urandom;
  endtask

  task automatic run_op(input md_op_t o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input bit ack);
    int w, lat;
    w = sel16 ? 16 : 32;
    issue(o, x, y);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) chk("in_ready_low", 32'(cur_rdy), 32'd0);
    end while (!cur_vld && lat < 200);
    chk($sformatf("%s latency", o.name()), 32'(lat), 32'(ref_lat(w, o, x, y)));
    chk($sformatf("%s result", o.name()), cur_res, exp);
    chk($sformatf("%s zero", o.name()), 32'(cur_zero), 32'(exp == 0));
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("ready_after_ack", 32'(cur_rdy), 32'd1);
      chk("valid_after_ack", 32'(cur_vld), 32'd0);
    end
  endtask

  md_op_t      d_op[13] = '{MD_MUL, MD_MULH, MD_MULHU, MD_MULHSU, MD_DIV, MD_REM, MD_DIVU,
                            MD_REMU, MD_REM, MD_DIVU, MD_REM, MD_DIV, MD_REM};
  logic [31:0] d_a[13]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                            32'hFFFF_FFF9, 32'd100, 32'd100, 32'd6, 32'd5, 32'd5,
                            32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b[13]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                            32'd2, 32'd7, 32'd7, 32'd3, 32'd0, 32'd0,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_e[13]  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                            32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'd0,
                            32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "timeout");
  end

  initial begin
    md_op_t      ro;
    logic [31:0] rx, ry;
    logic        seen;

    #1 rst_n = 1'b0;
    #2;
    chk("rst in_ready", 32'(rdy32), 32'd1);
    chk("rst out_valid", 32'(vld32), 32'd0);
    chk("rst result", res32, 32'd0);
    chk("rst zero", 32'(z32), 32'd1);
    chk("rst16 in_ready", 32'(rdy16), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op(d_op[i], d_a[i], d_b[i], d_e[i], 1'b1);

    for (int i = 0; i < 40; i++) begin
      ro = md_op_t'($urandom_range(0, 7));
      rx = pick(32);
      ry = pick(32);
      run_op(ro, rx, ry, ref_res(32, ro, rx, ry), 1'b1);
    end

    // Backpressure, then a back-to-back issue right after the handshake.
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bp out_valid", 32'(cur_vld), 32'd1);
      chk("bp result", cur_res, 32'd14);
      chk("bp in_ready", 32'(cur_rdy), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp ready_after_ack", 32'(cur_rdy), 32'd1);
    run_op(MD_REMU, 32'd100, 32'd7, 32'd2, 1'b1);

    // Kill a DIV at iteration 10.
    issue(MD_DIV, $urandom, 32'($urandom_range(1, 1000)));
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    chk("kill in_ready", 32'(cur_rdy), 32'd1);
    chk("kill out_valid", 32'(cur_vld), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (cur_vld) seen = 1'b1;
    end
    chk("kill no_valid", 32'(seen), 32'd0);
    run_op(MD_MUL, 32'd3, 32'd4, 32'd12, 1'b1);

    // Asynchronous reset in the middle of BUSY.
    issue(MD_MULH, $urandom, $urandom);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(cur_vld), 32'd0);
    chk("midrst in_ready", 32'(cur_rdy), 32'd1);
    chk("midrst result", cur_res, 32'd0);
    chk("midrst zero", 32'(cur_zero), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    sel16 = 1'b1;
    run_op(MD_MULHU, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFE, 1'b1);
    for (int i = 0; i < 16; i++) begin
      ro = md_op_t'($urandom_range(0, 7));
      rx = pick(16);
      ry = pick(16);
      run_op(ro, rx, ry, ref_res(16, ro, rx, ry), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
